// File: rtl/wb_buffer_pkg.sv
// Shared register-file constants and the writeback entry type used by the
// register file and the writeback buffer.
package rf_pkg;
  localparam int REG_DATA_WIDTH_POW = 6;
  localparam int REG_MEM_DEPTH_POW  = 5;
  localparam int REG_DATA_WIDTH     = 1 << REG_DATA_WIDTH_POW;

  typedef struct packed {
    logic [REG_MEM_DEPTH_POW-1:0] rd;
    logic [REG_DATA_WIDTH-1:0]    data;
  } wb_entry_t;
endpackage

// File: rtl/wb_buffer_if.sv
// Enqueue, register-file write and forwarding signals of the writeback buffer.
interface wb_buffer_if #(
  parameter int DW        = 64,
  parameter int RW        = 5,
  parameter int DEPTH_POW = 2
);
  logic                 enq_valid;
  logic                 enq_ready;
  logic [RW-1:0]        enq_rd;
  logic [DW-1:0]        enq_data;
  logic                 wr_hold;
  logic                 wr_en;
  logic [RW-1:0]        wr_rd;
  logic [DW-1:0]        wr_data;
  logic [RW-1:0]        fwd_rs1;
  logic [RW-1:0]        fwd_rs2;
  logic                 fwd1_hit;
  logic                 fwd2_hit;
  logic [DW-1:0]        fwd1_data;
  logic [DW-1:0]        fwd2_data;
  logic [DEPTH_POW:0]   count;

  modport master (
    output enq_valid, enq_rd, enq_data, wr_hold, fwd_rs1, fwd_rs2,
    input  enq_ready, wr_en, wr_rd, wr_data, fwd1_hit, fwd2_hit,
           fwd1_data, fwd2_data, count
  );

  modport slave (
    input  enq_valid, enq_rd, enq_data, wr_hold, fwd_rs1, fwd_rs2,
    output enq_ready, wr_en, wr_rd, wr_data, fwd1_hit, fwd2_hit,
           fwd1_data, fwd2_data, count
  );
endinterface

// File: rtl/wb_buffer_fwd_match.sv
// Forwarding lookup: searches occupied entries from the youngest (tail-1)
// towards the oldest and returns the first matching register value.
module wb_fwd_match
  import rf_pkg::*;
#(
  parameter int DEPTH_POW = 2
) (
  input  wb_entry_t [(1<<DEPTH_POW)-1:0] entries_i,
  input  logic [(1<<DEPTH_POW)-1:0]      occ_i,
  input  logic [DEPTH_POW-1:0]           tail_i,
  input  logic [REG_MEM_DEPTH_POW-1:0]   rs_i,
  output logic                           hit_o,
  output logic [REG_DATA_WIDTH-1:0]      data_o
);
  localparam int DEPTH = 1 << DEPTH_POW;

  logic [DEPTH_POW-1:0] idx;

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = tail_i - DEPTH_POW'(k + 1);
      if (!hit_o && occ_i[idx] && (rs_i != '0) && (entries_i[idx].rd == rs_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end
endmodule

// File: rtl/wb_buffer.sv
// In-order writeback buffer in front of the register file write port, with
// two combinational forwarding lookups over the queued results.
module wb_buffer #(
  parameter int REG_DATA_WIDTH_POW = rf_pkg::REG_DATA_WIDTH_POW,
  parameter int REG_MEM_DEPTH_POW  = rf_pkg::REG_MEM_DEPTH_POW,
  parameter int DEPTH_POW          = 2
) (
  input  logic       clk_in,
  input  logic       reset,
  wb_buffer_if.slave bus
);
  import rf_pkg::*;

  localparam int DEPTH = 1 << DEPTH_POW;
  localparam int DW    = 1 << REG_DATA_WIDTH_POW;
  localparam int RW    = REG_MEM_DEPTH_POW;

  localparam logic [DW-1:0] DATA_ZERO = '0;
  localparam logic [RW-1:0] RD_ZERO   = '0;

  typedef logic [DEPTH_POW-1:0] ptr_t;
  typedef logic [DEPTH_POW:0]   cnt_t;

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  ptr_t                  head_q, head_d;
  ptr_t                  tail_q, tail_d;
  cnt_t                  count_q, count_d;

  logic             full;
  logic             empty;
  logic             store;
  logic             drain;
  logic [DEPTH-1:0] occ;
  ptr_t             off;

  assign full  = (count_q == cnt_t'(DEPTH));
  assign empty = (count_q == '0);

  // x0 results complete the handshake but are never stored.
  assign store = bus.enq_valid && !full && (bus.enq_rd != RD_ZERO);
  assign drain = !empty && !bus.wr_hold;

  assign bus.enq_ready = !full;
  assign bus.wr_en     = drain;
  assign bus.wr_rd     = empty ? RD_ZERO   : mem_q[head_q].rd;
  assign bus.wr_data   = empty ? DATA_ZERO : mem_q[head_q].data;
  assign bus.count     = count_q;

  always_comb begin
    occ = '0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off    = ptr_t'(i) - head_q;
      occ[i] = (cnt_t'(off) < count_q);
    end
  end

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (store) begin
      mem_d[tail_q].rd   = bus.enq_rd;
      mem_d[tail_q].data = bus.enq_data;
      tail_d             = tail_q + ptr_t'(1);
    end
    if (drain) begin
      head_d = head_q + ptr_t'(1);
    end
    case ({store, drain})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  wb_fwd_match #(.DEPTH_POW(DEPTH_POW)) u_fwd1 (
    .entries_i (mem_q),
    .occ_i     (occ),
    .tail_i    (tail_q),
    .rs_i      (bus.fwd_rs1),
    .hit_o     (bus.fwd1_hit),
    .data_o    (bus.fwd1_data)
  );

  wb_fwd_match #(.DEPTH_POW(DEPTH_POW)) u_fwd2 (
    .entries_i (mem_q),
    .occ_i     (occ),
    .tail_i    (tail_q),
    .rs_i      (bus.fwd_rs2),
    .hit_o     (bus.fwd2_hit),
    .data_o    (bus.fwd2_data)
  );
endmodule

// File: doc/wb_buffer.md
# wb_buffer

Writeback buffer sitting directly upstream of the register file write port. Accepts completed results (destination register number plus 64-bit data) from the execute/memory stages, queues them in order, and drains one per cycle into the register file's `rd_in`/`data_write`/`write_en` inputs unless held off. Provides two combinational forwarding lookups, one per read port, so that decode sees values still queued and not yet written.

## Interface
- `REG_DATA_WIDTH_POW`, default 6: data width is 1 << this (64 bits).
- `REG_MEM_DEPTH_POW`, default 5: register-number width (32 registers).
- `DEPTH_POW`, default 2: buffer depth is 1 << this (4 entries); legal range 1..4.
- `clk_in`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `enq_valid`  in  1  producer offers a result this cycle.
- `enq_ready`  out  1  buffer can accept; equals not-full.
- `enq_rd`  in  REG_MEM_DEPTH_POW  destination register.
- `enq_data`  in  REG_DATA_WIDTH  result value.
- `wr_hold`  in  1  register file write port unavailable this cycle; suppresses drain.
- `wr_en`  out  1  to register file `write_en`.
- `wr_rd`  out  REG_MEM_DEPTH_POW  to register file `rd_in`.
- `wr_data`  out  REG_DATA_WIDTH  to register file `data_write`.
- `fwd_rs1`, `fwd_rs2`  in  REG_MEM_DEPTH_POW  source registers being read.
- `fwd1_hit`, `fwd2_hit`  out  1  a queued entry targets that register.
- `fwd1_data`, `fwd2_data`  out  REG_DATA_WIDTH  youngest queued value for that register.
- `count`  out  DEPTH_POW+1  number of occupied entries.

## Operation
- Circular FIFO: head and tail pointers of width DEPTH_POW, plus a count register of width DEPTH_POW+1. Full when count == 1<<DEPTH_POW; empty when count == 0.
- Enqueue fires when `enq_valid && enq_ready`. If `enq_rd == 0`, the handshake completes but nothing is stored, because x0 writes are discarded here, not at the register file.
- Drain: `wr_en = !empty && !wr_hold`, with `wr_rd`/`wr_data` driven from the head entry. When `wr_en` is 1, the head pops at the clock edge.
- `wr_rd`/`wr_data` hold the head contents whenever the buffer is non-empty. They are 0 when empty.
- Simultaneous enqueue and drain: count is unchanged and both pointers advance. When full, `enq_ready` stays 0 even if a drain occurs that cycle. There is no combinational ready-through-pop path.
- Pointers wrap modulo depth with no special handling.
- Forwarding: compare `fwd_rsN` against every occupied entry. The youngest match (closest to tail) wins.
  - `fwd_rsN == 0` never hits.
  - On a miss, `fwd_data` is 0.
  - An entry draining this cycle still forwards.
  - A same-cycle enqueue is not visible to forwarding.
- No flush input: all accepted results are architectural.

## Timing
- Reset values: `count` = 0, pointers = 0, `wr_en` = 0, `wr_rd`/`wr_data` = 0, hits = 0, `enq_ready` = 1. Entry storage is also cleared.
- Reset asserted mid-operation discards all queued entries immediately, without waiting for a clock edge.
- Latency: an entry accepted at edge N appears on `wr_*` in cycle N+1 if it reaches the head. It is written into the register file at edge N+1 provided `wr_hold` is 0.
- Forwarding outputs and `wr_*` are purely combinational from registered state plus `fwd_rsN`/`wr_hold`.
- Throughput: one enqueue and one drain per cycle, sustained.

## Structure
- Shared package `rf_pkg`:
  - Constants `REG_DATA_WIDTH_POW` and `REG_MEM_DEPTH_POW`, also used by the register file.
  - Typedef `wb_entry_t` as a packed struct of `rd` and `data`.
- One sub-module, `wb_fwd_match`: a priority search of the entry array from the youngest entry, returning hit and data. It is instantiated twice, once per read port.

## Test plan
- Reset, then enqueue rd=5/0xA5 with `wr_hold`=0: `wr_en`=1, `wr_rd`=5, `wr_data`=0xA5 in the next cycle. Afterwards `count` returns to 0.
- Hold `wr_hold`=1 and enqueue rd=1..4 with data 0x11..0x44: `count`=4 and `enq_ready`=0. A fifth offer is not accepted. Release the hold: writes drain in order 1, 2, 3, 4, one per cycle.
- Enqueue rd=7/0x1 and then rd=7/0x2 under hold, with `fwd_rs1`=7: `fwd1_hit`=1 and `fwd1_data`=0x2. `fwd_rs2`=0 gives hit=0 and data=0.
- Enqueue rd=0/0xFF: handshake completes, `count` stays 0, and `wr_en` never asserts.
- Run continuous enqueue with random `wr_hold` for 1000 cycles: the write sequence matches a scoreboard model and pointers wrap correctly past entry 3.
- Assert reset asynchronously between edges with 3 entries queued: `count`=0 and `wr_en`=0 immediately. After release, the old data never appears on `wr_*`.
